// File: rtl/util_1553_pkg.sv
// Shared constants for the MIL-STD-1553 bus-controller sequencer.
package util_1553_pkg;

    // Sequencer states
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SEND_CMD    = 3'd1;
    localparam logic [2:0] ST_SEND_DATA   = 3'd2;
    localparam logic [2:0] ST_WAIT_STATUS = 3'd3;
    localparam logic [2:0] ST_RECV_DATA   = 3'd4;
    localparam logic [2:0] ST_DONE        = 3'd5;

    // Command word fields (status word shares the RT field position)
    localparam int CMD_RT_MSB = 15;
    localparam int CMD_RT_LSB = 11;
    localparam int CMD_TR_BIT = 10;
    localparam int CMD_SA_MSB = 9;
    localparam int CMD_SA_LSB = 5;
    localparam int CMD_WC_MSB = 4;
    localparam int CMD_WC_LSB = 0;

    // AXIS tuser bits
    localparam int TUSER_SYNC_BIT   = 7;
    localparam int TUSER_PARITY_BIT = 0;

    localparam logic [4:0] MODE_SA0     = 5'd0;
    localparam logic [4:0] MODE_SA31    = 5'd31;
    localparam logic [4:0] BROADCAST_RT = 5'd31;

    // result = {timeout, sync_err, parity_err, addr_err}
    localparam int RES_TIMEOUT_BIT = 3;
    localparam int RES_SYNC_BIT    = 2;
    localparam int RES_PARITY_BIT  = 1;
    localparam int RES_ADDR_BIT    = 0;

    // Number of data words carried by a message; wc=0 encodes 32.
    function automatic logic [5:0] calc_nwords(input logic [4:0] sa, input logic [4:0] wc);
        if (sa == MODE_SA0 || sa == MODE_SA31) begin
            return wc[4] ? 6'd1 : 6'd0;
        end
        return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
    endfunction

endpackage

// File: rtl/util_1553_resp_timer.sv
// Response timer: reloads on every bus handshake, flags expiry RESP_CYCLES cycles later.
module util_1553_resp_timer #(
    parameter int unsigned CLOCK_SPEED     = 100000000,
    parameter int unsigned RESP_TIMEOUT_US = 40
) (
    input  logic aclk,
    input  logic arstn,
    input  logic load_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned RESP_CYCLES = CLOCK_SPEED / 1000000 * RESP_TIMEOUT_US;
    localparam int unsigned CNT_W       = $clog2(RESP_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    // Load to RESP_CYCLES-1 so the count hits zero exactly RESP_CYCLES cycles after the load.
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (clear_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (load_i) begin
            run_d = 1'b1;
            cnt_d = CNT_W'(RESP_CYCLES - 1);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Timer state
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/util_1553_bc_sequencer.sv
// MIL-STD-1553 bus-controller message sequencer with registered encoder and rx stages.
module util_1553_bc_sequencer
    import util_1553_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED     = 100000000,
    parameter int unsigned RESP_TIMEOUT_US = 40
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic [15:0] s_axis_cmd_tdata,
    input  logic        s_axis_cmd_tvalid,
    output logic        s_axis_cmd_tready,
    input  logic [15:0] s_axis_tx_tdata,
    input  logic        s_axis_tx_tvalid,
    output logic        s_axis_tx_tready,
    output logic [15:0] m_axis_enc_tdata,
    output logic        m_axis_enc_tvalid,
    output logic [7:0]  m_axis_enc_tuser,
    input  logic        m_axis_enc_tready,
    input  logic [15:0] s_axis_dec_tdata,
    input  logic        s_axis_dec_tvalid,
    input  logic [7:0]  s_axis_dec_tuser,
    output logic        s_axis_dec_tready,
    output logic [15:0] m_axis_rx_tdata,
    output logic        m_axis_rx_tvalid,
    output logic [7:0]  m_axis_rx_tuser,
    input  logic        m_axis_rx_tready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  result
);

    logic [2:0]  state_q, state_d;
    logic [4:0]  rt_q, rt_d;
    logic        tr_q, tr_d;
    logic        bcast_q, bcast_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  result_q, result_d;
    logic        run_q;
    logic        enc_tvalid_q, enc_tvalid_d;
    logic [15:0] enc_tdata_q, enc_tdata_d;
    logic [7:0]  enc_tuser_q, enc_tuser_d;
    logic        rx_tvalid_q, rx_tvalid_d;
    logic [15:0] rx_tdata_q, rx_tdata_d;
    logic [7:0]  rx_tuser_q, rx_tuser_d;
    logic [3:0]  err;

    logic cmd_hs, tx_hs, enc_hs, dec_hs, dec_accept;
    logic enc_free, rx_free, rx_phase, expire;

    // Handshakes and ready generation; run_q keeps every ready low while in reset.
    always_comb begin
        rx_phase          = (state_q == ST_WAIT_STATUS) || (state_q == ST_RECV_DATA);
        enc_free          = !enc_tvalid_q || m_axis_enc_tready;
        rx_free           = !rx_tvalid_q || m_axis_rx_tready;
        s_axis_cmd_tready = run_q && (state_q == ST_IDLE);
        s_axis_tx_tready  = run_q && (state_q == ST_SEND_DATA) && (cnt_q != 6'd0) && enc_free;
        if (rx_phase) begin
            s_axis_dec_tready = run_q && rx_free;
        end else begin
            // Words outside a response window are discarded
            s_axis_dec_tready = run_q && ((state_q == ST_IDLE) || (state_q == ST_SEND_CMD) ||
                                          (state_q == ST_SEND_DATA));
        end
        cmd_hs     = s_axis_cmd_tvalid && s_axis_cmd_tready;
        tx_hs      = s_axis_tx_tvalid && s_axis_tx_tready;
        enc_hs     = m_axis_enc_tvalid && m_axis_enc_tready;
        dec_hs     = s_axis_dec_tvalid && s_axis_dec_tready;
        dec_accept = dec_hs && rx_phase;
    end

    util_1553_resp_timer #(
        .CLOCK_SPEED     (CLOCK_SPEED),
        .RESP_TIMEOUT_US (RESP_TIMEOUT_US)
    ) u_resp_timer (
        .aclk     (aclk),
        .arstn    (arstn),
        .load_i   (enc_hs || dec_accept),
        .clear_i  ((state_q == ST_IDLE) || (state_q == ST_DONE)),
        .expire_o (expire)
    );

    // Sequencer next-state, encoder stage and rx stage
    always_comb begin
        state_d      = state_q;
        rt_d         = rt_q;
        tr_d         = tr_q;
        bcast_d      = bcast_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        enc_tvalid_d = enc_tvalid_q;
        enc_tdata_d  = enc_tdata_q;
        enc_tuser_d  = enc_tuser_q;
        rx_tvalid_d  = rx_tvalid_q;
        rx_tdata_d   = rx_tdata_q;
        rx_tuser_d   = rx_tuser_q;
        err          = 4'b0000;

        if (enc_hs) enc_tvalid_d = 1'b0;
        if (rx_tvalid_q && m_axis_rx_tready) rx_tvalid_d = 1'b0;
        // Every accepted response word goes to the host, including erroneous ones
        if (dec_accept) begin
            rx_tvalid_d = 1'b1;
            rx_tdata_d  = s_axis_dec_tdata;
            rx_tuser_d  = s_axis_dec_tuser;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    rt_d         = s_axis_cmd_tdata[CMD_RT_MSB:CMD_RT_LSB];
                    tr_d         = s_axis_cmd_tdata[CMD_TR_BIT];
                    bcast_d      = s_axis_cmd_tdata[CMD_RT_MSB:CMD_RT_LSB] == BROADCAST_RT;
                    cnt_d        = calc_nwords(s_axis_cmd_tdata[CMD_SA_MSB:CMD_SA_LSB],
                                               s_axis_cmd_tdata[CMD_WC_MSB:CMD_WC_LSB]);
                    enc_tvalid_d = 1'b1;
                    enc_tdata_d  = s_axis_cmd_tdata;
                    enc_tuser_d  = 8'h80;
                    state_d      = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                if (enc_hs) begin
                    if (tr_q) begin
                        state_d = ST_WAIT_STATUS;
                    end else if (cnt_q != 6'd0) begin
                        state_d = ST_SEND_DATA;
                    end else if (bcast_q) begin
                        result_d = 4'b0000;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_STATUS;
                    end
                end
            end
            ST_SEND_DATA: begin
                if (tx_hs) begin
                    enc_tvalid_d = 1'b1;
                    enc_tdata_d  = s_axis_tx_tdata;
                    enc_tuser_d  = 8'h00;
                    cnt_d        = cnt_q - 6'd1;
                end
                // Leave only once the last data word has left the encoder stage
                if (enc_hs && cnt_q == 6'd0) begin
                    if (bcast_q) begin
                        result_d = 4'b0000;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_STATUS;
                    end
                end
            end
            ST_WAIT_STATUS: begin
                if (dec_accept) begin
                    err[RES_SYNC_BIT]   = !s_axis_dec_tuser[TUSER_SYNC_BIT];
                    err[RES_PARITY_BIT] = !s_axis_dec_tuser[TUSER_PARITY_BIT];
                    err[RES_ADDR_BIT]   = s_axis_dec_tdata[CMD_RT_MSB:CMD_RT_LSB] != rt_q;
                    if (err != 4'b0000 || !tr_q || cnt_q == 6'd0) begin
                        result_d = err;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_RECV_DATA;
                    end
                end else if (expire) begin
                    result_d                  = 4'b0000;
                    result_d[RES_TIMEOUT_BIT] = 1'b1;
                    state_d                   = ST_DONE;
                end
            end
            ST_RECV_DATA: begin
                if (dec_accept) begin
                    err[RES_SYNC_BIT]   = s_axis_dec_tuser[TUSER_SYNC_BIT];
                    err[RES_PARITY_BIT] = !s_axis_dec_tuser[TUSER_PARITY_BIT];
                    cnt_d               = cnt_q - 6'd1;
                    if (err != 4'b0000 || cnt_q == 6'd1) begin
                        result_d = err;
                        state_d  = ST_DONE;
                    end
                end else if (expire) begin
                    result_d                  = 4'b0000;
                    result_d[RES_TIMEOUT_BIT] = 1'b1;
                    state_d                   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= ST_IDLE;
            rt_q         <= 5'd0;
            tr_q         <= 1'b0;
            bcast_q      <= 1'b0;
            cnt_q        <= 6'd0;
            result_q     <= 4'b0000;
            run_q        <= 1'b0;
            enc_tvalid_q <= 1'b0;
            enc_tdata_q  <= 16'h0000;
            enc_tuser_q  <= 8'h00;
            rx_tvalid_q  <= 1'b0;
            rx_tdata_q   <= 16'h0000;
            rx_tuser_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            rt_q         <= rt_d;
            tr_q         <= tr_d;
            bcast_q      <= bcast_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            run_q        <= 1'b1;
            enc_tvalid_q <= enc_tvalid_d;
            enc_tdata_q  <= enc_tdata_d;
            enc_tuser_q  <= enc_tuser_d;
            rx_tvalid_q  <= rx_tvalid_d;
            rx_tdata_q   <= rx_tdata_d;
            rx_tuser_q   <= rx_tuser_d;
        end
    end

    assign m_axis_enc_tvalid = enc_tvalid_q;
    assign m_axis_enc_tdata  = enc_tdata_q;
    assign m_axis_enc_tuser  = enc_tuser_q;
    assign m_axis_rx_tvalid  = rx_tvalid_q;
    assign m_axis_rx_tdata   = rx_tdata_q;
    assign m_axis_rx_tuser   = rx_tuser_q;
    assign busy              = state_q != ST_IDLE;
    assign done              = state_q == ST_DONE;
    assign result            = result_q;

endmodule
